// File: rtl/robot_pkg.sv
// robot_pkg: shared definitions for the route sequencer.
//   - move encodings driven onto robot.move_i
//   - queued command codes, heading codes, error codes
//   - field limit and FSM state type
//   - step_to(): one-square neighbour of a position in a given direction,
//     with an ok flag that is low when the square would leave the field
package robot_pkg;

  localparam logic [2:0] MOVE_STAY  = 3'b000;
  localparam logic [2:0] MOVE_FWD   = 3'b111;
  localparam logic [2:0] MOVE_BACK  = 3'b011;
  localparam logic [2:0] MOVE_LEFT  = 3'b101;
  localparam logic [2:0] MOVE_RIGHT = 3'b110;

  localparam logic [1:0] CMD_FWD   = 2'b00;
  localparam logic [1:0] CMD_BACK  = 2'b01;
  localparam logic [1:0] CMD_LEFT  = 2'b10;
  localparam logic [1:0] CMD_RIGHT = 2'b11;

  localparam logic [1:0] HEAD_W = 2'b00;
  localparam logic [1:0] HEAD_N = 2'b01;
  localparam logic [1:0] HEAD_E = 2'b10;
  localparam logic [1:0] HEAD_S = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BOUNDS   = 2'b01;
  localparam logic [1:0] ERR_OBSTACLE = 2'b10;
  localparam logic [1:0] ERR_PWR      = 2'b11;

  localparam logic [2:0] FIELD_MAX = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_UP,
    ST_RUN,
    ST_ISSUE,
    ST_SETTLE,
    ST_PWR_DN,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] x;
    logic [2:0] y;
  } step_t;

  // Neighbouring square in direction dir. Flipping bit 1 of a heading gives
  // the opposite direction (W<->E, N<->S), which is how BACK reuses this.
  function automatic step_t step_to(input logic [1:0] dir,
                                    input logic [2:0] x,
                                    input logic [2:0] y);
    step_t s;
    s.ok = 1'b1;
    s.x  = x;
    s.y  = y;
    case (dir)
      HEAD_W:  if (x == 3'd0)      s.ok = 1'b0; else s.x = x - 3'd1;
      HEAD_N:  if (y >= FIELD_MAX) s.ok = 1'b0; else s.y = y + 3'd1;
      HEAD_E:  if (x >= FIELD_MAX) s.ok = 1'b0; else s.x = x + 3'd1;
      default: if (y == 3'd0)      s.ok = 1'b0; else s.y = y - 3'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/robot_cmd_fifo.sv
// robot_cmd_fifo: synchronous command queue with registered full/empty flags.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : drop all entries (wins over a same-cycle write/read)
//   wr_en/wr_data: write request; ignored while full
//   rd_en        : pop request; ignored while empty
//   rd_data      : head entry (valid while !empty)
//   full, empty  : occupancy flags, registered
module robot_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  logic              do_wr;
  logic              do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)      count_nxt = count + 1'b1;
    else if (do_rd && !do_wr) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/robot_route_ctrl.sv
// robot_route_ctrl: route sequencer in front of the robot block. Queues
// high-level commands, powers the motors up/down with a timeout, issues each
// command as a one-cycle move pulse followed by one STAY cycle, and tracks
// heading and position on the 7x7 field.
//
// Optional feature: define ROUTE_OBSTACLE_STOP_EN to stop on obstacles. A FWD
// popped while tracker_status_i=1 is suppressed, err_code_o becomes 10, the
// queue is flushed and the motors are powered down. Without the macro
// tracker_status_i is ignored.
//
// Ports:
//   clk_i, rstn_i         : clock, asynchronous active-low reset
//   start_i, stop_i       : one-cycle pulses (power up and run / power down)
//   cmd_valid_i, cmd_i    : command write (00 FWD, 01 BACK, 10 LEFT, 11 RIGHT)
//   cmd_ready_o           : queue not full
//   motor_status_i        : motor power feedback from the robot
//   tracker_status_i      : obstacle ahead from the robot tracker
//   motor_on_o, move_o    : drive to the robot
//   x_o, y_o, heading_o   : tracked position and heading (00 W,01 N,10 E,11 S)
//   busy_o                : not in IDLE or ERROR
//   err_code_o            : 00 none, 01 bounds, 10 obstacle, 11 power timeout
module robot_route_ctrl
  import robot_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         PWR_TIMEOUT = 8,
  parameter logic [2:0] X0          = 3'd5,
  parameter logic [2:0] Y0          = 3'd1,
  parameter logic [1:0] H0          = 2'b01
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       motor_status_i,
  input  logic       tracker_status_i,
  output logic       motor_on_o,
  output logic [2:0] move_o,
  output logic [2:0] x_o,
  output logic [2:0] y_o,
  output logic [1:0] heading_o,
  output logic       busy_o,
  output logic [1:0] err_code_o
);

  localparam int CNT_W = $clog2(PWR_TIMEOUT + 1);
  // The edge that sees this value is the PWR_TIMEOUT-th cycle in the state.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(PWR_TIMEOUT - 1);

  state_t         state;
  logic [CNT_W-1:0] cnt;

  logic           fifo_full;
  logic           fifo_empty;
  logic [1:0]     fifo_data;
  logic           pop;
  logic           flush;
  logic           obstacle;

  // Outcome of the popped command, computed when it leaves the queue and
  // committed on the edge that ends ISSUE.
  logic           acc_q;
  logic           obst_q;
  logic [2:0]     nx_q;
  logic [2:0]     ny_q;
  logic [1:0]     nh_q;

  step_t          fwd_step;
  step_t          back_step;

  assign pop         = (state == ST_RUN) && !fifo_empty;
  assign flush       = (state == ST_ISSUE) && obst_q;
  assign cmd_ready_o = !fifo_full;
  assign fwd_step    = step_to(heading_o, x_o, y_o);
  assign back_step   = step_to(heading_o ^ 2'b10, x_o, y_o);

`ifdef ROUTE_OBSTACLE_STOP_EN
  assign obstacle = tracker_status_i && (fifo_data == CMD_FWD);
`else
  logic unused_tracker;
  assign unused_tracker = tracker_status_i;
  assign obstacle       = 1'b0;
`endif

  robot_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (2)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .flush   (flush),
    .wr_en   (cmd_valid_i),
    .wr_data (cmd_i),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      motor_on_o <= 1'b0;
      move_o     <= MOVE_STAY;
      busy_o     <= 1'b0;
      err_code_o <= ERR_NONE;
      x_o        <= X0;
      y_o        <= Y0;
      heading_o  <= H0;
      acc_q      <= 1'b0;
      obst_q     <= 1'b0;
    end else begin
      // A new error raised later in this block overrides the clear.
      if (start_i) err_code_o <= ERR_NONE;

      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start_i) begin
            state      <= ST_PWR_UP;
            motor_on_o <= 1'b1;
            busy_o     <= 1'b1;
            cnt        <= '0;
          end
        end

        ST_PWR_UP: begin
          if (motor_status_i) begin
            state <= ST_RUN;
          end else if (cnt == TO_LAST) begin
            state      <= ST_ERROR;
            motor_on_o <= 1'b0;
            busy_o     <= 1'b0;
            err_code_o <= ERR_PWR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (!fifo_empty) begin
            state  <= ST_ISSUE;
            acc_q  <= 1'b1;
            obst_q <= 1'b0;
            move_o <= MOVE_STAY;
            nx_q   <= x_o;
            ny_q   <= y_o;
            nh_q   <= heading_o;
            case (fifo_data)
              CMD_FWD: begin
                if (obstacle) begin
                  acc_q      <= 1'b0;
                  obst_q     <= 1'b1;
                  err_code_o <= ERR_OBSTACLE;
                end else if (!fwd_step.ok) begin
                  acc_q      <= 1'b0;
                  err_code_o <= ERR_BOUNDS;
                end else begin
                  move_o <= MOVE_FWD;
                  nx_q   <= fwd_step.x;
                  ny_q   <= fwd_step.y;
                end
              end
              CMD_BACK: begin
                if (!back_step.ok) begin
                  acc_q      <= 1'b0;
                  err_code_o <= ERR_BOUNDS;
                end else begin
                  move_o <= MOVE_BACK;
                  nx_q   <= back_step.x;
                  ny_q   <= back_step.y;
                end
              end
              CMD_LEFT: begin
                move_o <= MOVE_LEFT;
                nh_q   <= heading_o - 2'd1;
              end
              default: begin
                move_o <= MOVE_RIGHT;
                nh_q   <= heading_o + 2'd1;
              end
            endcase
          end else if (stop_i) begin
            state      <= ST_PWR_DN;
            motor_on_o <= 1'b0;
            cnt        <= '0;
          end
        end

        ST_ISSUE: begin
          move_o <= MOVE_STAY;
          if (acc_q) begin
            x_o       <= nx_q;
            y_o       <= ny_q;
            heading_o <= nh_q;
          end
          if (obst_q) begin
            state      <= ST_PWR_DN;
            motor_on_o <= 1'b0;
            cnt        <= '0;
          end else begin
            state <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          state <= ST_RUN;
        end

        ST_PWR_DN: begin
          if (!motor_status_i || (cnt == TO_LAST)) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          motor_on_o <= 1'b0;
          move_o     <= MOVE_STAY;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_robot_route_ctrl.sv
// tb_robot_route_ctrl: scoreboard bench for robot_route_ctrl. Stimulus pushes
// the expected move pulses into a queue; a negedge monitor pops and compares
// each pulse the DUT emits and checks the STAY cycle that follows it.
module tb_robot_route_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       motor_status;
  logic       tracker;
  logic       motor_on;
  logic [2:0] move;
  logic [2:0] x;
  logic [2:0] y;
  logic [1:0] heading;
  logic       busy;
  logic [1:0] err_code;

  logic       pwr_follow;
  logic [2:0] exp_q[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         last_pulse = -1;
  bit         cad_en = 1'b0;
  bit         prev_pulse = 1'b0;

  always #5 clk = ~clk;

  robot_route_ctrl dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .start_i          (start),
    .stop_i           (stop),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_i            (cmd),
    .motor_status_i   (motor_status),
    .tracker_status_i (tracker),
    .motor_on_o       (motor_on),
    .move_o           (move),
    .x_o              (x),
    .y_o              (y),
    .heading_o        (heading),
    .busy_o           (busy),
    .err_code_o       (err_code)
  );

  // Motor feedback: follows motor_on one step later when enabled.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    motor_status = pwr_follow & motor_on;
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act == exp) passes = passes + 1;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [2:0] e;
    if (prev_pulse) check("settle_stay", int'(move), 0);
    prev_pulse = 1'b0;
    if (rstn && move != 3'b000) begin
      prev_pulse = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(move), 0);
      end else begin
        e = exp_q.pop_front();
        check("move_pulse", int'(move), int'(e));
      end
      if (cad_en && last_pulse >= 0) check("cadence", cyc - last_pulse, 3);
      last_pulse = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic push(input logic [1:0] c, input logic [2:0] e, input bit expect_pulse);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("push_ready_timeout", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
    if (expect_pulse) exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("idle", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; cmd_valid = 1'b0; cmd = 2'b00;
    tracker = 1'b0; pwr_follow = 1'b1; motor_status = 1'b0;
    #12;
    do_reset();

    // Reset state
    check("rst_motor_on", int'(motor_on), 0);
    check("rst_move", int'(move), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err_code), 0);
    check("rst_x", int'(x), 5);
    check("rst_y", int'(y), 1);
    check("rst_heading", int'(heading), 1);

    // FWD, FWD, LEFT, FWD from (5,1) N -> (4,3) W; queue fills to 4
    push(2'b00, 3'b111, 1'b1);
    push(2'b00, 3'b111, 1'b1);
    push(2'b10, 3'b101, 1'b1);
    push(2'b00, 3'b111, 1'b1);
    check("full_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd = 2'b11;
    tick();
    cmd_valid = 1'b0;
    check("full_reject_ready", int'(cmd_ready), 0);
    cad_en = 1'b1; last_pulse = -1;
    pulse_start();
    check("start_motor_on", int'(motor_on), 1);
    check("start_busy", int'(busy), 1);
    wait_drain();
    repeat (3) tick();
    cad_en = 1'b0;
    check("seq_x", int'(x), 4);
    check("seq_y", int'(y), 3);
    check("seq_heading", int'(heading), 0);
    check("seq_err", int'(err_code), 0);
    check("seq_ready", int'(cmd_ready), 1);
    pulse_stop();
    check("stop_motor_off", int'(motor_on), 0);
    wait_idle();

    // RIGHT, FWD, FWD: second FWD would reach x=7 and is rejected
    do_reset();
    push(2'b11, 3'b110, 1'b1);
    push(2'b00, 3'b111, 1'b1);
    push(2'b00, 3'b111, 1'b0);
    pulse_start();
    wait_drain();
    repeat (6) tick();
    check("bounds_err", int'(err_code), 1);
    check("bounds_x", int'(x), 6);
    check("bounds_y", int'(y), 1);
    check("bounds_heading", int'(heading), 2);
    pulse_stop();
    wait_idle();
    check("bounds_err_sticky", int'(err_code), 1);
    pulse_start();
    check("start_clears_err", int'(err_code), 0);
    tick();
    pulse_stop();
    wait_idle();

    // Power-up timeout: ERROR 8 cycles after motor_on rises
    do_reset();
    pwr_follow = 1'b0;
    pulse_start();
    check("to_motor_on", int'(motor_on), 1);
    repeat (7) tick();
    check("to_still_busy", int'(busy), 1);
    check("to_still_on", int'(motor_on), 1);
    tick();
    check("to_busy", int'(busy), 0);
    check("to_motor_off", int'(motor_on), 0);
    check("to_err", int'(err_code), 3);
    // Recover from ERROR with a queued command
    pwr_follow = 1'b1;
    push(2'b00, 3'b111, 1'b1);
    pulse_start();
    check("recover_err", int'(err_code), 0);
    wait_drain();
    repeat (3) tick();
    check("recover_x", int'(x), 5);
    check("recover_y", int'(y), 2);
    pulse_stop();
    wait_idle();

    // Obstacle handling
    do_reset();
    tracker = 1'b1;
`ifdef ROUTE_OBSTACLE_STOP_EN
    push(2'b00, 3'b111, 1'b0);
    push(2'b10, 3'b101, 1'b0);
    pulse_start();
    repeat (8) tick();
    wait_idle();
    check("obst_err", int'(err_code), 2);
    check("obst_motor_off", int'(motor_on), 0);
    check("obst_ready", int'(cmd_ready), 1);
    check("obst_y", int'(y), 1);
    check("obst_heading", int'(heading), 1);
    tracker = 1'b0;
    pulse_start();
    repeat (10) tick();
    check("obst_flushed_heading", int'(heading), 1);
    pulse_stop();
    wait_idle();
`else
    push(2'b00, 3'b111, 1'b1);
    pulse_start();
    wait_drain();
    repeat (3) tick();
    check("tracker_ignored_y", int'(y), 2);
    check("tracker_ignored_err", int'(err_code), 0);
    pulse_stop();
    wait_idle();
`endif
    tracker = 1'b0;

    // Reset asserted during ISSUE
    do_reset();
    push(2'b00, 3'b111, 1'b0);
    pulse_start();
    for (int n = 0; n < 20; n++) begin
      tick();
      if (move == 3'b111) break;
    end
    check("issue_seen", int'(move), 7);
    rstn = 1'b0;
    #1;
    check("rst_issue_move", int'(move), 0);
    check("rst_issue_motor", int'(motor_on), 0);
    #1;
    rstn = 1'b1;
    tick();
    tick();
    check("rst_issue_x", int'(x), 5);
    check("rst_issue_y", int'(y), 1);
    check("rst_issue_heading", int'(heading), 1);
    check("rst_issue_busy", int'(busy), 0);
    check("rst_issue_ready", int'(cmd_ready), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
